dcache_miss_ctrl: RTL and testbench

Miss-handling sequencer for the data cache. It detects a load or store that misses the cache and stalls the pipeline. If the victim line is dirty, it writes it back to `data_mem` first, then refills the requested 128-bit block and releases the stall. It sits between the memory stage, the `cache` block (`hit`, dirty/victim tag, `fetch_enable`) and `data_mem` (`wr_en`, `addr`). It also keeps saturating miss and write-back counters for performance analysis.

---
 rtl/dcache_miss_ctrl.sv | 104 ++++++++++
 tb/tb_dcache_miss_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer: stalls on a miss, writes back a dirty victim,
// refills the requested block, and keeps saturating miss/write-back counters.
module dcache_miss_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2,
  parameter int OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic                  hit,
  input  logic                  victim_dirty,
  input  logic [DATA_WIDTH-1:0] victim_addr,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  refill_en,
  output logic [15:0]           miss_cnt,
  output logic [15:0]           wb_cnt
);

  // state     | meaning
  // IDLE      | pipeline running; lookup result watched for a miss
  // WRITEBACK | dirty victim block being written to data_mem
  // REFILL    | requested block being fetched; refill_en on last cycle
  // RESUME    | cache tag/valid/dirty update before releasing the stall
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESUME} state_t;

  localparam logic [DATA_WIDTH-1:0] OFF_MASK = DATA_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);
  localparam logic [3:0]            LAT_LAST = 4'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0] req_blk_q, wb_blk_q;
  logic [DATA_WIDTH-1:0] addr_blk;
  logic                  access, miss, lat_done;

  assign access   = rd_en | wr_en;
  assign miss     = access & ~hit;
  assign addr_blk = addr & ~OFF_MASK;
  assign lat_done = (lat_cnt_q == LAT_LAST);

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    stall     = 1'b1;
    wb_valid  = 1'b0;
    refill_en = 1'b0;
    mem_addr  = req_blk_q;
    case (state_q)
      IDLE: begin
        stall     = miss;
        mem_addr  = addr_blk;
        lat_cnt_d = '0;
        if (miss) state_d = victim_dirty ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_addr = wb_blk_q;
        wb_valid = (lat_cnt_q == 4'd0);
        if (lat_done) begin
          lat_cnt_d = '0;
          state_d   = REFILL;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      REFILL: begin
        if (lat_done) begin
          refill_en = 1'b1;
          lat_cnt_d = '0;
          state_d   = RESUME;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      RESUME:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      req_blk_q <= '0;
      wb_blk_q  <= '0;
      miss_cnt  <= '0;
      wb_cnt    <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      // Request and victim are captured once; later input changes are ignored.
      if (state_q == IDLE && miss) begin
        req_blk_q <= addr_blk;
        wb_blk_q  <= victim_addr & ~OFF_MASK;
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        if (victim_dirty && wb_cnt != 16'hFFFF) wb_cnt <= wb_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: directed scenarios plus random traffic checked
// against a timeline model of each miss sequence.
module tb_dcache_miss_ctrl;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n, rd_en, wr_en, hit, victim_dirty;
  logic [31:0] addr, victim_addr, mem_addr;
  logic        stall, wb_valid, refill_en;
  logic [15:0] miss_cnt, wb_cnt;

  logic        s_rst_n, s_rd_en, s_hit;
  logic [31:0] s_mem_addr;
  logic        s_stall, s_wb_valid, s_refill_en;
  logic [15:0] s_miss_cnt, s_wb_cnt;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  dcache_miss_ctrl #(.DATA_WIDTH(32), .MEM_LATENCY(L), .OFFSET_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .hit(hit),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .stall(stall),
    .wb_valid(wb_valid), .mem_addr(mem_addr), .refill_en(refill_en),
    .miss_cnt(miss_cnt), .wb_cnt(wb_cnt));

  dcache_miss_ctrl #(.DATA_WIDTH(32), .MEM_LATENCY(1), .OFFSET_BITS(4)) dut_sat (
    .clk(clk), .rst_n(s_rst_n), .rd_en(s_rd_en), .wr_en(1'b0), .addr(32'h0000_8004), .hit(s_hit),
    .victim_dirty(1'b0), .victim_addr(32'h0000_9000), .stall(s_stall),
    .wb_valid(s_wb_valid), .mem_addr(s_mem_addr), .refill_en(s_refill_en),
    .miss_cnt(s_miss_cnt), .wb_cnt(s_wb_cnt));

  // Reference model: one active miss at a time, described by its start cycle.
  int          cyc = 0;
  bit          have_seq = 0;
  int          miss_t = 0;
  bit          m_dirty = 0;
  logic [31:0] m_req = '0, m_wb = '0;
  int          m_miss = 0, m_wbc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    int   off, dur, last;
    bit   act, start;
    logic exp_stall, exp_wb, exp_ref, chk_addr;
    logic [31:0] exp_addr;
    @(negedge clk);
    exp_stall = 1'b0; exp_wb = 1'b0; exp_ref = 1'b0; chk_addr = 1'b1;
    exp_addr  = addr & ~32'hF;
    start     = 1'b0;
    if (!rst_n) begin
      have_seq  = 0; m_miss = 0; m_wbc = 0;
      exp_stall = (rd_en | wr_en) & ~hit;
    end else begin
      dur = m_dirty ? 2*L + 2 : L + 2;
      act = have_seq && (cyc - miss_t) < dur;
      if (!act && (rd_en | wr_en) && !hit) begin
        have_seq = 1; miss_t = cyc; m_dirty = victim_dirty;
        m_req = addr & ~32'hF; m_wb = victim_addr & ~32'hF;
        act = 1; start = 1;
      end
      if (act) begin
        off = cyc - miss_t;
        last = m_dirty ? 2*L : L;
        exp_stall = 1'b1;
        if (off > 0) begin
          if (m_dirty && off <= L) begin
            exp_addr = m_wb;
            exp_wb   = (off == 1);
          end else if (off <= last) begin
            exp_addr = m_req;
            exp_ref  = (off == last);
          end else begin
            chk_addr = 1'b0;
          end
        end
      end
    end
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("wb_valid", 32'(wb_valid), 32'(exp_wb));
    chk("refill_en", 32'(refill_en), 32'(exp_ref));
    if (chk_addr) chk("mem_addr", mem_addr, exp_addr);
    chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    chk("wb_cnt", 32'(wb_cnt), 32'(m_wbc));
    if (start) begin
      m_miss = (m_miss < 65535) ? m_miss + 1 : 65535;
      if (m_dirty) m_wbc = (m_wbc < 65535) ? m_wbc + 1 : 65535;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; s_rst_n = 1'b0; s_rd_en = 1'b0; s_hit = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; hit = 1'b1; victim_dirty = 1'b0;
    addr = 32'h0; victim_addr = 32'h0;
    step(); step();
    rst_n = 1'b1; s_rst_n = 1'b1;
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_wb_cnt", 32'(wb_cnt), 32'd0);

    // Load hits 0x100..0x124
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1; hit = 1'b1; addr = 32'h100 + 32'(4*i);
      step();
    end

    // Clean load miss
    addr = 32'h1004; hit = 1'b0; victim_dirty = 1'b0; victim_addr = 32'hABC0;
    step();
    hit = 1'b1;
    repeat (4) step();
    chk("t2_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("t2_wb_cnt", 32'(wb_cnt), 32'd0);

    // Dirty store miss
    rd_en = 1'b0; wr_en = 1'b1; addr = 32'h300C; hit = 1'b0;
    victim_dirty = 1'b1; victim_addr = 32'h2038;
    step();
    hit = 1'b1;
    repeat (6) step();
    chk("t3_miss_cnt", 32'(miss_cnt), 32'd2);
    chk("t3_wb_cnt", 32'(wb_cnt), 32'd1);

    // Input isolation during REFILL
    wr_en = 1'b0; rd_en = 1'b1; addr = 32'h4008; hit = 1'b0; victim_dirty = 1'b0;
    step();
    step();
    addr = 32'h5000; rd_en = 1'b0;
    repeat (4) step();

    // Reset in the second WRITEBACK cycle
    rd_en = 1'b1; addr = 32'h6010; hit = 1'b0; victim_dirty = 1'b1; victim_addr = 32'h7000;
    step(); step();
    hit = 1'b1; rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("t4_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("t4_wb_cnt", 32'(wb_cnt), 32'd0);

    // Back-to-back misses
    rd_en = 1'b1; hit = 1'b0; addr = 32'hA000; victim_dirty = 1'b0;
    repeat (12) step();

    // Random traffic, inputs also wiggled while busy
    for (int i = 0; i < 400; i++) begin
      rd_en        = ($urandom_range(0, 3) == 0);
      wr_en        = ($urandom_range(0, 3) == 0);
      hit          = ($urandom_range(0, 2) != 0);
      victim_dirty = $urandom_range(0, 1) == 1;
      addr         = $urandom;
      victim_addr  = $urandom;
      step();
    end
    rd_en = 1'b0; wr_en = 1'b0;

    // Saturation with MEM_LATENCY = 1: a miss every 3 cycles
    s_hit = 1'b0; s_rd_en = 1'b1;
    for (int k = 1; k <= 65537; k++) begin
      repeat (3) @(posedge clk);
      #1;
      if (k == 1 || k == 2 || k >= 65534) begin
        chk("sat_miss_cnt", 32'(s_miss_cnt), (k < 65535) ? 32'(k) : 32'hFFFF);
        chk("sat_stall", 32'(s_stall), 32'd1);
      end
    end
    chk("sat_wb_cnt", 32'(s_wb_cnt), 32'd0);
    chk("sat_mem_addr", s_mem_addr, 32'h0000_8000);
    s_rd_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
